// File: rtl/pool_frame_sequencer.sv
// pool_frame_sequencer
// Reads one feature-map frame out of a synchronous single-port buffer and streams it,
// channel-interleaved (ch innermost), to the pooling datapath with line/frame framing.
// Lines are separated by LINE_GAP idle cycles so downstream pool counters can roll over.
//
// state  | meaning
// IDLE   | waiting for start_i, no reads, busy_o low
// READ   | one buffer read per cycle, ch/pix/line advance with ch innermost
// GAP    | LINE_GAP idle cycles between lines, no reads
// FLUSH  | 2 cycles letting the two-stage read pipeline drain
// DONE   | done_o high for one cycle, start_i ignored here
module pool_frame_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNEL_NUM = 3,
    parameter int STRING_LEN  = 4,
    parameter int LINE_NUM    = 4,
    parameter int LINE_GAP    = 2,
    parameter int ADDR_WIDTH  = ((CHANNEL_NUM * STRING_LEN * LINE_NUM) > 1)
                                ? $clog2(CHANNEL_NUM * STRING_LEN * LINE_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  mem_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic                  sof_o,
    output logic                  eof_o,
    output logic                  busy_o,
    output logic                  done_o
);

    // Counter widths are forced to at least 1 bit so degenerate 1-sized dimensions still build.
    localparam int CH_W   = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int PIX_W  = (STRING_LEN > 1)  ? $clog2(STRING_LEN)  : 1;
    localparam int LINE_W = (LINE_NUM > 1)    ? $clog2(LINE_NUM)    : 1;
    localparam int GAP_W  = (LINE_GAP > 1)    ? $clog2(LINE_GAP)    : 1;

    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNEL_NUM - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(STRING_LEN - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINE_NUM - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(LINE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_GAP   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [CH_W-1:0]       ch_q, ch_d;
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                  flush_cnt_q, flush_cnt_d;
    logic                  rd_q, rd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Stage 1: framing of the read issued last cycle, waiting for its buffer data.
    logic s1_valid_q, s1_valid_d;
    logic s1_sop_q, s1_sop_d;
    logic s1_eop_q, s1_eop_d;
    logic s1_sof_q, s1_sof_d;
    logic s1_eof_q, s1_eof_d;

    // Stage 2: registered stream outputs.
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic valid_q, valid_d;
    logic sop_q, sop_d;
    logic eop_q, eop_d;
    logic sof_q, sof_d;
    logic eof_q, eof_d;

    logic kill;
    logic word_sop;
    logic word_eop;

    // Next-state, counters and read strobe; counters always describe the word being read now.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        pix_d       = pix_q;
        line_d      = line_q;
        addr_d      = addr_q;
        gap_cnt_d   = gap_cnt_q;
        flush_cnt_d = flush_cnt_q;
        rd_d        = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort_i wins over a simultaneous start_i
                if (start_i && !abort_i) begin
                    state_d = S_READ;
                    ch_d    = '0;
                    pix_d   = '0;
                    line_d  = '0;
                    addr_d  = '0;
                    rd_d    = 1'b1;
                end
            end
            S_READ: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (ch_q != CH_LAST) begin
                        ch_d = ch_q + CH_W'(1);
                        rd_d = 1'b1;
                    end else if (pix_q != PIX_LAST) begin
                        ch_d  = '0;
                        pix_d = pix_q + PIX_W'(1);
                        rd_d  = 1'b1;
                    end else if (line_q != LINE_LAST) begin
                        ch_d      = '0;
                        pix_d     = '0;
                        line_d    = line_q + LINE_W'(1);
                        gap_cnt_d = GAP_LOAD;
                        state_d   = S_GAP;
                    end else begin
                        flush_cnt_d = 1'b1;
                        state_d     = S_FLUSH;
                    end
                end
            end
            S_GAP: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_READ;
                    rd_d    = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            S_FLUSH: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (flush_cnt_q == 1'b0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    flush_cnt_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Framing pipeline; an abort empties both stages so no partial frame leaks out.
    always_comb begin
        kill     = abort_i && ((state_q == S_READ) || (state_q == S_GAP) || (state_q == S_FLUSH));
        word_sop = (ch_q == '0) && (pix_q == '0);
        word_eop = (ch_q == CH_LAST) && (pix_q == PIX_LAST);

        s1_valid_d = rd_q && !kill;
        s1_sop_d   = s1_valid_d && word_sop;
        s1_eop_d   = s1_valid_d && word_eop;
        s1_sof_d   = s1_sop_d && (line_q == '0);
        s1_eof_d   = s1_eop_d && (line_q == LINE_LAST);

        valid_d = s1_valid_q && !kill;
        sop_d   = s1_sop_q && !kill;
        eop_d   = s1_eop_q && !kill;
        sof_d   = s1_sof_q && !kill;
        eof_d   = s1_eof_q && !kill;
        data_d  = valid_d ? mem_data_i : '0;
    end

    // All state and registered outputs; reset discards any frame in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            pix_q       <= '0;
            line_q      <= '0;
            addr_q      <= '0;
            gap_cnt_q   <= '0;
            flush_cnt_q <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sop_q    <= 1'b0;
            s1_eop_q    <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
            addr_q      <= addr_d;
            gap_cnt_q   <= gap_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            s1_valid_q  <= s1_valid_d;
            s1_sop_q    <= s1_sop_d;
            s1_eop_q    <= s1_eop_d;
            s1_sof_q    <= s1_sof_d;
            s1_eof_q    <= s1_eof_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
        end
    end

    assign mem_rd_o   = rd_q;
    assign mem_addr_o = addr_q;
    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign sop_o      = sop_q;
    assign eop_o      = eop_q;
    assign sof_o      = sof_q;
    assign eof_o      = eof_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_pool_frame_sequencer.sv
// Bench for pool_frame_sequencer: a 3x4x4 instance exercised with random buffer contents,
// random aborts/resets and back-to-back starts, plus a 1x1x1 instance for the single-word frame.
module tb_pool_frame_sequencer;

    localparam int CH  = 3;
    localparam int SL  = 4;
    localparam int LN  = 4;
    localparam int GAP = 2;
    localparam int W   = CH * SL;
    localparam int P   = W + GAP;
    localparam int N   = W * LN;
    localparam int AW  = $clog2(N);

    logic          clk;
    logic          reset_n;
    logic          start_i;
    logic          abort_i;
    logic          mem_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_data_i;
    logic [7:0]    data_o;
    logic          valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, done_o;

    logic          s_start, s_abort, s_rd;
    logic [0:0]    s_addr;
    logic [7:0]    s_mem_q, s_data;
    logic          s_valid, s_sop, s_eop, s_sof, s_eof, s_busy, s_done;

    logic [7:0] mem [0:N-1];
    logic [7:0] s_mem;

    int n_cmp = 0;
    int n_err = 0;

    pool_frame_sequencer #(
        .DATA_WIDTH(8), .CHANNEL_NUM(CH), .STRING_LEN(SL), .LINE_NUM(LN), .LINE_GAP(GAP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .abort_i(abort_i),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .data_o(data_o), .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o),
        .sof_o(sof_o), .eof_o(eof_o), .busy_o(busy_o), .done_o(done_o)
    );

    pool_frame_sequencer #(
        .DATA_WIDTH(8), .CHANNEL_NUM(1), .STRING_LEN(1), .LINE_NUM(1), .LINE_GAP(2)
    ) dut_small (
        .clk(clk), .reset_n(reset_n), .start_i(s_start), .abort_i(s_abort),
        .mem_rd_o(s_rd), .mem_addr_o(s_addr), .mem_data_i(s_mem_q),
        .data_o(s_data), .valid_o(s_valid), .sop_o(s_sop), .eop_o(s_eop),
        .sof_o(s_sof), .eof_o(s_eof), .busy_o(s_busy), .done_o(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous single-port buffers: data one cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd_o) mem_data_i <= mem[mem_addr_o];
        if (s_rd) s_mem_q <= s_mem;
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference schedule: offset o counts cycles after the start-accepting edge.
    // Reads occupy the first w cycles of each p-cycle line slot, starting at offset 1.
    function automatic bit rd_at(input int o, input int w, input int p, input int l);
        int r;
        r = o - 1;
        return (r >= 0) && (r < l * p) && ((r % p) < w);
    endfunction

    function automatic int word_at(input int o, input int w, input int p);
        int r;
        r = o - 1;
        return (r / p) * w + (r % p);
    endfunction

    // last read offset + 2 cycles of latency gives eof, done one cycle later
    function automatic int done_off(input int w, input int p, input int l);
        return (l - 1) * p + w + 3;
    endfunction

    // One frame on the main instance. kill_off != 0: abort (or reset if kill_rst) in that cycle.
    task automatic run_frame(input bit hold, input int kill_off, input bit kill_rst);
        int  d;
        bit  live, e_rd, e_v;
        int  wd, k, ln;
        logic [3:0] e_flags;
        logic [7:0] e_data;
        d = done_off(W, P, LN);
        foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
        start_i = 1'b1;
        for (int o = 1; o <= d + 1; o++) begin
            @(negedge clk);
            live = (kill_off == 0) || (o <= kill_off);
            e_rd = live && rd_at(o, W, P, LN);
            chk_val("mem_rd", 32'(mem_rd_o), 32'(e_rd));
            if (e_rd) chk_val("mem_addr", 32'(mem_addr_o), 32'(word_at(o, W, P)));
            e_v = live && rd_at(o - 2, W, P, LN);
            chk_val("valid", 32'(valid_o), 32'(e_v));
            e_flags = 4'b0;
            if (e_v) begin
                wd      = word_at(o - 2, W, P);
                k       = (o - 3) % P;
                ln      = (o - 3) / P;
                e_data  = mem[wd];
                e_flags = {k == 0, k == W - 1, (k == 0) && (ln == 0), (k == W - 1) && (ln == LN - 1)};
                chk_val("data", 32'(data_o), 32'(e_data));
            end
            chk_val("sop_eop_sof_eof", 32'({sop_o, eop_o, sof_o, eof_o}), 32'(e_flags));
            chk_val("busy", 32'(busy_o), 32'(live && (o <= d)));
            chk_val("done", 32'(done_o), 32'(live && (o == d)));
            if (o == 1 && !hold) start_i = 1'b0;
            if (kill_off != 0 && o == kill_off) begin
                if (kill_rst) begin
                    reset_n = 1'b0;
                    #1;
                    chk_val("rst_async_outs",
                            32'({mem_rd_o, valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, done_o}), 32'(0));
                    chk_val("rst_async_data", 32'(data_o), 32'(0));
                end else begin
                    abort_i = 1'b1;
                end
            end
            if (kill_off != 0 && o == kill_off + 1) begin
                abort_i = 1'b0;
                reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        int d;
        int mode;
        d = done_off(W, P, LN);
        reset_n = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        s_start = 1'b0;
        s_abort = 1'b0;
        s_mem   = 8'h00;
        foreach (mem[i]) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk_val("reset_outs",
                32'({mem_rd_o, valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, done_o}), 32'(0));
        chk_val("reset_data", 32'(data_o), 32'(0));
        chk_val("reset_addr", 32'(mem_addr_o), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk_val("idle_busy", 32'(busy_o), 32'(0));

        // abort while idle does nothing
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk_val("idle_abort_busy", 32'(busy_o), 32'(0));
        chk_val("idle_abort_rd", 32'(mem_rd_o), 32'(0));

        // normal frame, framing and timing
        run_frame(1'b0, 0, 1'b0);
        // start held high across frames: restart only after done
        run_frame(1'b1, 0, 1'b0);
        run_frame(1'b1, 0, 1'b0);
        run_frame(1'b0, 0, 1'b0);
        // abort while reading address 27, then a clean frame
        run_frame(1'b0, 1 + 2 * P + 3, 1'b0);
        run_frame(1'b0, 0, 1'b0);
        // reset pulsed in the first gap cycle, then a clean frame
        run_frame(1'b0, W + 1, 1'b1);
        run_frame(1'b0, 0, 1'b0);

        for (int it = 0; it < 10; it++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                1:       run_frame(1'b0, int'($urandom_range(1, d - 1)), 1'b0);
                2:       run_frame(1'b1, 0, 1'b0);
                3:       run_frame(1'b0, int'($urandom_range(1, d - 1)), 1'b1);
                default: run_frame(1'b0, 0, 1'b0);
            endcase
        end
        run_frame(1'b0, 0, 1'b0);
        start_i = 1'b0;

        // single-word frame on the 1x1x1 instance
        begin
            int sd;
            bit e_v;
            sd = done_off(1, 3, 1);
            s_mem = 8'($urandom_range(0, 255));
            s_start = 1'b1;
            for (int o = 1; o <= sd + 1; o++) begin
                @(negedge clk);
                chk_val("s_mem_rd", 32'(s_rd), 32'(rd_at(o, 1, 3, 1)));
                if (rd_at(o, 1, 3, 1)) chk_val("s_mem_addr", 32'(s_addr), 32'(0));
                e_v = rd_at(o - 2, 1, 3, 1);
                chk_val("s_valid", 32'(s_valid), 32'(e_v));
                chk_val("s_flags", 32'({s_sop, s_eop, s_sof, s_eof}), e_v ? 32'(4'hF) : 32'(0));
                if (e_v) chk_val("s_data", 32'(s_data), 32'(s_mem));
                chk_val("s_busy", 32'(s_busy), 32'(o <= sd));
                chk_val("s_done", 32'(s_done), 32'(o == sd));
                if (o == 1) s_start = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
